// File: rtl/arm_mem_pkg.sv
// Shared constants for the Thumb memory stage: opcodes, special register
// indices, and the multi-register sequencer state/kind encodings.
package arm_mem_pkg;

  // Instruction bits 15:9 for the multi-register forms
  localparam logic [6:0] OP_PUSH        = 7'b1011010;
  localparam logic [6:0] OP_POP         = 7'b1011110;
  localparam logic [4:0] STORE_MULTIPLE = 5'b11000;
  localparam logic [4:0] LOAD_MULTIPLE  = 5'b11001;

  // Word-size single-access codes forwarded to data_mem (STR/LDR immediate)
  localparam logic [6:0] MEM_STR_WORD = 7'b0110000;
  localparam logic [6:0] MEM_LDR_WORD = 7'b0110100;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_t;

  typedef enum logic [2:0] {K_NONE, K_PUSH, K_POP, K_STM, K_LDM} seq_kind_t;

endpackage

// File: rtl/ldm_stm_seq_lsb_pick.sv
// Lowest-set-bit finder over a 9-bit register mask: returns the bit index and
// a one-hot mask selecting that bit so the caller can clear it.
module lsb_pick (
  input  logic [8:0] vec,
  output logic [3:0] idx,
  output logic [8:0] clr
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    idx = '0;
    clr = '0;
    for (int i = 8; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
        clr = 9'(1) << i;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// Multi-register memory sequencer: expands PUSH/POP/STMIA/LDMIA register lists
// into one word access per cycle, returns load data to the register file and
// writes back the updated base register at completion.
module ldm_stm_seq
  import arm_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  op_code,
  input  logic [8:0]  reg_list,
  input  logic [31:0] base_val,
  output logic [3:0]  reg_rd_addr,
  input  logic [31:0] reg_rd_data,
  output logic [6:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic        mem_write_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_we,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done
);

  seq_state_t  state_q, state_nxt;
  seq_kind_t   kind_d, kind_q;
  logic [8:0]  mask_d, mask_q, mask_nxt, pick_clr;
  logic [3:0]  n_d, pick_idx, cur_reg, extra_d, extra_q;
  logic [2:0]  rn_d;
  logic [31:0] start_addr, wb_val_d, wb_data_q;
  logic [3:0]  wb_addr_d, wb_addr_q;
  logic        wb_pend_d, wb_pend_q;
  logic        store_d, accept, store_q;
  logic [31:0] addr_q;
  logic        mem_we_q;
  logic [6:0]  mem_op_q;
  logic        vld_p1;
  logic [3:0]  idx_p1;

  assign accept = start && (state_q == IDLE);

  // Decode the incoming instruction: register set, count, start address and base result
  always_comb begin
    kind_d  = K_NONE;
    mask_d  = '0;
    extra_d = '0;
    if (op_code == OP_PUSH) begin
      kind_d  = K_PUSH;
      mask_d  = reg_list;
      extra_d = REG_LR;
    end else if (op_code == OP_POP) begin
      kind_d  = K_POP;
      mask_d  = reg_list;
      extra_d = REG_PC;
    end else if (op_code[6:2] == STORE_MULTIPLE) begin
      kind_d  = K_STM;
      mask_d  = {1'b0, reg_list[7:0]};
    end else if (op_code[6:2] == LOAD_MULTIPLE) begin
      kind_d  = K_LDM;
      mask_d  = {1'b0, reg_list[7:0]};
    end
    rn_d = {op_code[1:0], reg_list[8]};
    n_d  = '0;
    for (int i = 0; i < 9; i++) begin
      n_d = n_d + {3'b000, mask_d[i]};
    end
    store_d    = (kind_d == K_PUSH) || (kind_d == K_STM);
    start_addr = (kind_d == K_PUSH) ? base_val - {26'd0, n_d, 2'b00} : base_val;
    wb_val_d   = (kind_d == K_PUSH) ? base_val - {26'd0, n_d, 2'b00}
                                    : base_val + {26'd0, n_d, 2'b00};
    wb_addr_d  = ((kind_d == K_PUSH) || (kind_d == K_POP)) ? REG_SP : {1'b0, rn_d};
    // LDM with the base in the list keeps the loaded value instead of the increment
    wb_pend_d  = (n_d != 4'd0) && !((kind_d == K_LDM) && mask_d[rn_d]);
  end

  lsb_pick u_pick (
    .vec (mask_q),
    .idx (pick_idx),
    .clr (pick_clr)
  );

  assign mask_nxt = mask_q & ~pick_clr;
  assign cur_reg  = (pick_idx == 4'd8) ? extra_q : pick_idx;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and status/writeback outputs
  always_comb begin
    state_nxt   = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    wb_we       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    reg_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_nxt = (n_d != 4'd0) ? RUN : DRAIN;
      end
      RUN: begin
        busy = 1'b1;
        if (store_q) reg_rd_addr = cur_reg;
        if (mask_nxt == 9'd0) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
        if (wb_pend_q) begin
          wb_we   = 1'b1;
          wb_addr = wb_addr_q;
          wb_data = wb_data_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access sequencing: capture on accept, then step address and mask each RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q    <= '0;
      kind_q    <= K_NONE;
      extra_q   <= '0;
      store_q   <= 1'b0;
      wb_pend_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      addr_q    <= '0;
      mem_we_q  <= 1'b0;
      mem_op_q  <= '0;
      vld_p1    <= 1'b0;
      idx_p1    <= '0;
    end else begin
      // p0 -> p1: load index delayed to line up with registered read data
      vld_p1 <= (state_q == RUN) && (kind_q == K_POP || kind_q == K_LDM);
      idx_p1 <= ((state_q == RUN) && !store_q) ? cur_reg : 4'd0;
      if (accept) begin
        mask_q    <= mask_d;
        kind_q    <= kind_d;
        extra_q   <= extra_d;
        store_q   <= store_d;
        wb_pend_q <= wb_pend_d;
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_val_d;
        addr_q    <= (n_d != 4'd0) ? start_addr : 32'd0;
        mem_we_q  <= (n_d != 4'd0) && store_d;
        mem_op_q  <= (n_d == 4'd0) ? 7'd0 : (store_d ? MEM_STR_WORD : MEM_LDR_WORD);
      end else if (state_q == RUN) begin
        mask_q <= mask_nxt;
        if (mask_nxt != 9'd0) begin
          addr_q <= addr_q + 32'd4;
        end else begin
          addr_q   <= '0;
          mem_we_q <= 1'b0;
          mem_op_q <= '0;
        end
      end
    end
  end

  assign mem_addr     = addr_q;
  assign mem_write_en = mem_we_q;
  assign mem_op       = mem_op_q;
  assign mem_wdata    = mem_we_q ? reg_rd_data : 32'd0;
  assign rf_we        = vld_p1;
  assign rf_waddr     = idx_p1;
  assign rf_wdata     = vld_p1 ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: cycle-by-cycle expectations for PUSH, POP,
// LDM, STM, empty list, mid-operation reset and a start held while busy.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [6:0]  op_code;
  logic [8:0]  reg_list;
  logic [31:0] base_val;
  logic [3:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [6:0]  mem_op;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_we;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy, done;

  logic [31:0] regs [0:15];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign reg_rd_data = regs[reg_rd_addr];

  ldm_stm_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .op_code      (op_code),
    .reg_list     (reg_list),
    .base_val     (base_val),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_data  (reg_rd_data),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;
    regs[0] = 32'h11; regs[2] = 32'h22; regs[7] = 32'h77; regs[14] = 32'h33;
    rst_n = 1'b0; start = 1'b0; op_code = '0; reg_list = '0; base_val = '0; mem_rdata = '0;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_write_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_op", mem_op, 0);
    check("rst_rfwe", rf_we, 0);
    check("rst_wbwe", wb_we, 0);
    check("rst_rdaddr", reg_rd_addr, 0);
    rst_n = 1'b1;
    tick;

    // PUSH {R0,R2,LR}, SP=0x100
    op_code = 7'b1011010; reg_list = 9'h105; base_val = 32'h100; start = 1'b1;
    #1 check("push_c0_busy", busy, 0);
    tick; start = 1'b0;
    check("push_c1_busy", busy, 1);
    check("push_c1_we", mem_write_en, 1);
    check("push_c1_op", mem_op, 7'b0110000);
    check("push_c1_addr", mem_addr, 32'hF4);
    check("push_c1_wd", mem_wdata, 32'h11);
    tick;
    check("push_c2_addr", mem_addr, 32'hF8);
    check("push_c2_wd", mem_wdata, 32'h22);
    tick;
    check("push_c3_addr", mem_addr, 32'hFC);
    check("push_c3_rd", reg_rd_addr, 14);
    check("push_c3_wd", mem_wdata, 32'h33);
    check("push_c3_done", done, 0);
    tick;
    check("push_c4_we", mem_write_en, 0);
    check("push_c4_done", done, 1);
    check("push_c4_wbwe", wb_we, 1);
    check("push_c4_wbaddr", wb_addr, 13);
    check("push_c4_wbdata", wb_data, 32'hF4);
    tick;
    check("push_c5_busy", busy, 0);
    check("push_c5_wbwe", wb_we, 0);

    // POP {R1,PC}, SP=0x200
    op_code = 7'b1011110; reg_list = 9'h102; base_val = 32'h200; start = 1'b1;
    tick; start = 1'b0;
    check("pop_c1_addr", mem_addr, 32'h200);
    check("pop_c1_we", mem_write_en, 0);
    check("pop_c1_op", mem_op, 7'b0110100);
    check("pop_c1_rfwe", rf_we, 0);
    tick; mem_rdata = 32'hAA; #1;
    check("pop_c2_addr", mem_addr, 32'h204);
    check("pop_c2_rfwe", rf_we, 1);
    check("pop_c2_rfwa", rf_waddr, 1);
    check("pop_c2_rfwd", rf_wdata, 32'hAA);
    tick; mem_rdata = 32'hBB; #1;
    check("pop_c3_rfwe", rf_we, 1);
    check("pop_c3_rfwa", rf_waddr, 15);
    check("pop_c3_rfwd", rf_wdata, 32'hBB);
    check("pop_c3_done", done, 1);
    check("pop_c3_wbwe", wb_we, 1);
    check("pop_c3_wbaddr", wb_addr, 13);
    check("pop_c3_wbdata", wb_data, 32'h208);
    tick;
    check("pop_c4_rfwe", rf_we, 0);
    check("pop_c4_busy", busy, 0);

    // LDM R3!,{R3,R4}, base 0x40: base in list, no writeback
    op_code = 7'b1100101; reg_list = 9'h118; base_val = 32'h40; start = 1'b1;
    tick; start = 1'b0;
    check("ldm_c1_addr", mem_addr, 32'h40);
    tick; mem_rdata = 32'h5; #1;
    check("ldm_c2_addr", mem_addr, 32'h44);
    check("ldm_c2_rfwa", rf_waddr, 3);
    check("ldm_c2_rfwd", rf_wdata, 32'h5);
    tick; mem_rdata = 32'h6; #1;
    check("ldm_c3_rfwe", rf_we, 1);
    check("ldm_c3_rfwa", rf_waddr, 4);
    check("ldm_c3_rfwd", rf_wdata, 32'h6);
    check("ldm_c3_done", done, 1);
    check("ldm_c3_wbwe", wb_we, 0);
    tick;

    // STM R1!,{R0,R7}, base 0x80
    op_code = 7'b1100000; reg_list = 9'h181; base_val = 32'h80; start = 1'b1;
    tick; start = 1'b0;
    check("stm_c1_addr", mem_addr, 32'h80);
    check("stm_c1_we", mem_write_en, 1);
    check("stm_c1_wd", mem_wdata, 32'h11);
    tick;
    check("stm_c2_addr", mem_addr, 32'h84);
    check("stm_c2_wd", mem_wdata, 32'h77);
    tick;
    check("stm_c3_we", mem_write_en, 0);
    check("stm_c3_wbwe", wb_we, 1);
    check("stm_c3_wbaddr", wb_addr, 1);
    check("stm_c3_wbdata", wb_data, 32'h88);
    tick;

    // STM with empty list
    op_code = 7'b1100000; reg_list = 9'h000; base_val = 32'h60; start = 1'b1;
    tick; start = 1'b0;
    check("empty_c1_done", done, 1);
    check("empty_c1_busy", busy, 1);
    check("empty_c1_we", mem_write_en, 0);
    check("empty_c1_wbwe", wb_we, 0);
    tick;
    check("empty_c2_busy", busy, 0);

    // PUSH of nine registers, reset during cycle 3
    op_code = 7'b1011010; reg_list = 9'h1FF; base_val = 32'h400; start = 1'b1;
    tick; start = 1'b0;
    check("rpush_c1_addr", mem_addr, 32'h3DC);
    check("rpush_c1_wd", mem_wdata, 32'h11);
    tick;
    check("rpush_c2_addr", mem_addr, 32'h3E0);
    check("rpush_c2_wd", mem_wdata, 32'h1001);
    tick;
    check("rpush_c3_addr", mem_addr, 32'h3E4);
    check("rpush_c3_we", mem_write_en, 1);
    rst_n = 1'b0;
    tick;
    check("rpush_c4_we", mem_write_en, 0);
    check("rpush_c4_busy", busy, 0);
    check("rpush_c4_addr", mem_addr, 0);
    check("rpush_c4_wbwe", wb_we, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("rpush_after_we", mem_write_en, 0);
      check("rpush_after_wbwe", wb_we, 0);
      check("rpush_after_busy", busy, 0);
    end

    // STM R2!,{R0}, base 0x300, start held; then PUSH {R2}, SP=0x500
    op_code = 7'b1100001; reg_list = 9'h001; base_val = 32'h300; start = 1'b1;
    tick;
    op_code = 7'b1011010; reg_list = 9'h004; base_val = 32'h500;
    #1;
    check("held_c1_addr", mem_addr, 32'h300);
    check("held_c1_wd", mem_wdata, 32'h11);
    tick;
    check("held_c2_done", done, 1);
    check("held_c2_wbaddr", wb_addr, 2);
    check("held_c2_wbdata", wb_data, 32'h304);
    check("held_c2_we", mem_write_en, 0);
    tick;
    check("held_c3_busy", busy, 0);
    tick; start = 1'b0;
    check("held_c4_addr", mem_addr, 32'h4FC);
    check("held_c4_we", mem_write_en, 1);
    check("held_c4_wd", mem_wdata, 32'h22);
    tick;
    check("held_c5_wbwe", wb_we, 1);
    check("held_c5_wbaddr", wb_addr, 13);
    check("held_c5_wbdata", wb_data, 32'h4FC);
    tick;
    check("held_c6_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multi-register memory sequencer for the Thumb memory stage. It sits between the pipeline's execute/memory control and `data_mem`, acting as the initiator that `data_mem` responds to. On PUSH, POP, STMIA and LDMIA it expands the 9-bit register list into one word access per cycle and drives address, write enable and store data into `data_mem`. It returns load data to the register file and writes back the updated base register (SP or Rn). While `busy` is high it stalls the front of the pipeline.

## Interface
Parameters: none. Opcode and register-index constants come from the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `start`  in  1  accept a new instruction; honoured only when `busy`=0
- `op_code`  in  7  instruction bits 15:9; must be PUSH `1011010`, POP `1011110`, STM `11000??` or LDM `11001??`
- `reg_list`  in  9  instruction bits 8:0
- `base_val`  in  32  value of SP (PUSH/POP) or Rn (STM/LDM), sampled on `start`
- `reg_rd_addr`  out  4  register-file read index for store data
- `reg_rd_data`  in  32  combinational register-file read data for `reg_rd_addr`
- `mem_op`  out  7  opcode forwarded to `data_mem.opCode`; always a word-size code
- `mem_addr`  out  32  byte address to `data_mem`
- `mem_write_en`  out  1  store strobe to `data_mem`
- `mem_wdata`  out  32  store data; equals `reg_rd_data`
- `mem_rdata`  in  32  `data_mem.mem_data_out`; valid the cycle after its address
- `rf_we`, `rf_waddr[3:0]`, `rf_wdata[31:0]`  out  load writeback port
- `wb_we`, `wb_addr[3:0]`, `wb_data[31:0]`  out  base-register writeback port
- `busy`  out  1  sequencer occupied
- `done`  out  1  one-cycle completion pulse

## Operation
- Captured on accept: `mask` (8 regs plus extra bit), `n` = popcount of the selected registers (0–9), `rn` = {`op_code[1:0]`, `reg_list[8]`}, and the kind.
- Register set:
  - PUSH: R0–R7 plus R14 if `reg_list[8]`.
  - POP: R0–R7 plus R15 if `reg_list[8]`.
  - STM/LDM: R0–R7 only; `reg_list[8]` is part of Rn.
- Start address, incrementing by 4 per access, ascending register order:
  - PUSH: `base_val` − 4n.
  - All others: `base_val`.
- Access order: lowest-numbered pending register first. Each cycle, clear the lowest set bit of `mask`.
- Base writeback:
  - PUSH → SP = `base_val` − 4n.
  - POP → SP = `base_val` + 4n.
  - STM → Rn = `base_val` + 4n.
  - LDM → Rn = `base_val` + 4n only if Rn is not in the list.
  - `wb_addr` = 13 for PUSH/POP, otherwise `rn`.
- Stores: `reg_rd_addr` = current register, `mem_write_en`=1, `mem_wdata` = `reg_rd_data`.
- Loads: `mem_write_en`=0. A 4-bit index pipeline delays the register number by one cycle. `rf_waddr` takes the delayed index and `rf_wdata` = `mem_rdata`.
- Arithmetic: 32-bit modulo. Address wrap-around is not detected.
- FSM states and transitions:
  - IDLE → RUN on accepted `start` with n>0.
  - IDLE → DRAIN on accepted `start` with n=0. An empty list makes no accesses and no base writeback.
  - RUN → DRAIN after the access whose `mask` becomes empty.
  - DRAIN → IDLE unconditionally.
- `start` while `busy`=1 is ignored, including in DRAIN.
- Reset values (all outputs 0 in IDLE or reset): `busy`, `done`, `mem_write_en`, `rf_we`, `wb_we` = 0; `mem_addr`, `mem_op`, `mem_wdata`, `rf_waddr`, `rf_wdata`, `wb_addr`, `wb_data`, `reg_rd_addr` = 0; state = IDLE.
- Reset mid-operation: the next edge returns the FSM to IDLE with all enables low. No further memory writes, no pending load writeback, no base writeback.

## Timing
- Cycle 0: `start` accepted (IDLE, `busy`=0).
- Cycles 1..n: RUN. Access k (k = 0..n−1) is presented in cycle k+1. `busy`=1.
- Cycles 2..n+1: load k is written back in cycle k+2 (`rf_we`=1).
- Cycle n+1: DRAIN with `busy`=1 and `done`=1; `wb_we` pulses if writeback applies.
- Cycle n+2: IDLE; earliest next accept.
- Empty list: DRAIN at cycle 1 with `done`=1, `wb_we`=0.
- `mem_addr`, `mem_op`, `mem_write_en` and `rf_*` are registered (flop-driven). `mem_wdata` is a combinational pass of `reg_rd_data`.

## Structure
- Package `arm_mem_pkg`:
  - opcode constants PUSH, POP, STORE_MULTIPLE, LOAD_MULTIPLE;
  - register indices SP=13, LR=14, PC=15;
  - state enum `seq_state_t` {IDLE, RUN, DRAIN}.
- Sub-module `lsb_pick`: 9-bit lowest-set-bit finder, returning a 4-bit index and a one-hot clear mask. Used for register selection; popcount stays inline.

## Test plan
- PUSH {R0,R2,LR}, SP=0x100, R0=0x11, R2=0x22, R14=0x33 → writes 0x0F4←0x11, 0x0F8←0x22, 0x0FC←0x33 in cycles 1–3; cycle 4 `wb_we` SP=0x0F4, `done`=1.
- POP {R1,PC}, SP=0x200, mem[0x200]=0xAA, mem[0x204]=0xBB → R1=0xAA in cycle 2, R15=0xBB in cycle 3, SP=0x208 in cycle 3.
- LDM R3!,{R3,R4}, base 0x40, mem=0x5,0x6 → R3=0x5, R4=0x6, no `wb_we`. STM R1!,{R0,R7}, base 0x80 → R1=0x88.
- STM with empty list → `done` at cycle 1, `mem_write_en` never high, `wb_we`=0.
- PUSH of 9 registers, `rst_n`=0 at cycle 3 → `mem_write_en` low from cycle 4, no SP writeback, `busy`=0.
- Second `start` held during RUN/DRAIN → ignored; accepted at cycle n+2 with correct new addresses.
